// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS control sequencer (optional immediate ALU ops under MC_CTRL_IMM_EN)
module mc_control_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_source,
  output logic [3:0]           state,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instr_retired
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
`ifdef MC_CTRL_IMM_EN
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11,
`endif
    S_HALT      = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_IMM_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
`endif

  state_t                state_q;
  state_t                state_d;
  ctrl_t                 ctrl;
  logic                  retire;
  logic                  is_store_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  // The opcode is only trusted in DECODE; remember lw vs sw for MEM_ADR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      is_store_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        is_store_q <= (opcode == OP_SW);
      end
      if (retire) begin
        cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.pc_write  = mem_ready;
        ctrl.ir_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:       state_d = S_EXECUTE;
          OP_LW, OP_SW:   state_d = S_MEM_ADR;
          OP_BEQ:         state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
`ifdef MC_CTRL_IMM_EN
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMM_EXEC;
`endif
          default:        state_d = S_HALT;
        endcase
      end
      S_MEM_ADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d        = is_store_q ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
        retire          = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
        state_d        = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_d        = S_FETCH;
        retire         = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        state_d            = S_FETCH;
        retire             = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
        state_d        = S_FETCH;
        retire         = 1'b1;
      end
`ifdef MC_CTRL_IMM_EN
      S_IMM_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = 2'b11;
        state_d        = S_IMM_WB;
      end
      S_IMM_WB: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
        retire         = 1'b1;
      end
`endif
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Strobes are suppressed during reset so an abandoned instruction writes nothing.
  assign pc_write      = ctrl.pc_write      & ~rst;
  assign pc_write_cond = ctrl.pc_write_cond & ~rst;
  assign i_or_d        = ctrl.i_or_d        & ~rst;
  assign mem_read      = ctrl.mem_read      & ~rst;
  assign mem_write     = ctrl.mem_write     & ~rst;
  assign ir_write      = ctrl.ir_write      & ~rst;
  assign mem_to_reg    = ctrl.mem_to_reg    & ~rst;
  assign reg_dst       = ctrl.reg_dst       & ~rst;
  assign reg_write     = ctrl.reg_write     & ~rst;
  assign alu_src_a     = ctrl.alu_src_a     & ~rst;
  assign alu_src_b     = ctrl.alu_src_b     & {2{~rst}};
  assign alu_op        = ctrl.alu_op        & {2{~rst}};
  assign pc_source     = ctrl.pc_source     & {2{~rst}};
  assign halted        = (state_q == S_HALT) & ~rst;
  assign state         = state_q;
  assign instr_retired = cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm driven by random instruction streams
module tb_mc_control_fsm;

  localparam int CW = 4;
`ifdef MC_CTRL_IMM_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    opcode = 6'd0;
  logic          mem_ready = 1'b0;
  logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic          mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, alu_op, pc_source;
  logic [3:0]    state;
  logic          halted;
  logic [CW-1:0] instr_retired;

  mc_control_fsm #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .halted(halted),
    .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          in_rst;
    logic [3:0]    st;
    logic [15:0]   ctrl;
    logic          halt;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [CW-1:0] m_cnt = '0;

  // Control word: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
  function automatic logic [15:0] ctrl_of(input int st, input logic mr);
    logic [15:0] c;
    c = '0;
    case (st)
      0:  begin c[12] = 1'b1; c[5:4] = 2'b01; c[15] = mr; c[10] = mr; end
      1:  c[5:4] = 2'b11;
      2:  begin c[6] = 1'b1; c[5:4] = 2'b10; end
      3:  begin c[12] = 1'b1; c[13] = 1'b1; end
      4:  begin c[7] = 1'b1; c[9] = 1'b1; end
      5:  begin c[11] = 1'b1; c[13] = 1'b1; end
      6:  begin c[6] = 1'b1; c[3:2] = 2'b10; end
      7:  begin c[7] = 1'b1; c[8] = 1'b1; end
      8:  begin c[6] = 1'b1; c[3:2] = 2'b01; c[14] = 1'b1; c[1:0] = 2'b01; end
      9:  begin c[15] = 1'b1; c[1:0] = 2'b10; end
      10: begin c[6] = 1'b1; c[5:4] = 2'b10; c[3:2] = 2'b11; end
      11: c[7] = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic step(input logic r, input int st, input logic mr, input logic [5:0] op,
                      input logic halt);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    mem_ready = mr;
    opcode    = op;
    e.in_rst  = r;
    e.st      = 4'(st);
    e.ctrl    = r ? 16'd0 : ctrl_of(st, mr);
    e.halt    = halt;
    e.cnt     = m_cnt;
    sb.push_back(e);
  endtask

  task automatic do_reset(input logic [5:0] op);
    step(1'b1, 0, 1'($urandom_range(0, 1)), op, 1'b0);
    m_cnt = '0;
  endtask

  task automatic mem_phase(input int st, input logic [5:0] op);
    int n;
    n = $urandom_range(0, 3);
    repeat (n) step(1'b0, st, 1'b0, op, 1'b0);
    step(1'b0, st, 1'b1, op, 1'b0);
  endtask

  function automatic bit is_imm(input logic [5:0] op);
    return (op == 6'b001000) || (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001010);
  endfunction

  // One instruction expressed as its architectural state path.
  task automatic run_instr(input logic [5:0] op);
    mem_phase(0, op);
    step(1'b0, 1, 1'($urandom_range(0, 1)), op, 1'b0);
    if (op == 6'b000000) begin
      step(1'b0, 6, 1'($urandom_range(0, 1)), op, 1'b0);
      step(1'b0, 7, 1'($urandom_range(0, 1)), op, 1'b0);
    end else if (op == 6'b100011) begin
      step(1'b0, 2, 1'($urandom_range(0, 1)), op, 1'b0);
      mem_phase(3, op);
      step(1'b0, 4, 1'($urandom_range(0, 1)), op, 1'b0);
    end else if (op == 6'b101011) begin
      step(1'b0, 2, 1'($urandom_range(0, 1)), op, 1'b0);
      mem_phase(5, op);
    end else if (op == 6'b000100) begin
      step(1'b0, 8, 1'($urandom_range(0, 1)), op, 1'b0);
    end else if (op == 6'b000010) begin
      step(1'b0, 9, 1'($urandom_range(0, 1)), op, 1'b0);
    end else if (is_imm(op) && IMM_EN) begin
      step(1'b0, 10, 1'($urandom_range(0, 1)), op, 1'b0);
      step(1'b0, 11, 1'($urandom_range(0, 1)), op, 1'b0);
    end else begin
      repeat (22) step(1'b0, 15, 1'($urandom_range(0, 1)), op, 1'b1);
      do_reset(op);
      return;
    end
    m_cnt = m_cnt + 1'b1;
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] table_ops [10];
    table_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                  6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b111111};
    if ($urandom_range(0, 15) == 0) return table_ops[9];
    return table_ops[$urandom_range(0, 8)];
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
        chk("ctrl", int'(act), int'(e.ctrl));
        chk("halted", int'(halted), int'(e.halt));
        if (!e.in_rst) begin
          chk("state", int'(state), int'(e.st));
          chk("instr_retired", int'(instr_retired), int'(e.cnt));
        end
      end
    end
  end

  initial begin : stimulus
    do_reset(6'd0);
    // Reset while a lw is stalled in MEM_READ.
    step(1'b0, 0, 1'b1, 6'b100011, 1'b0);
    step(1'b0, 1, 1'b1, 6'b100011, 1'b0);
    step(1'b0, 2, 1'b0, 6'b100011, 1'b0);
    step(1'b0, 3, 1'b0, 6'b100011, 1'b0);
    step(1'b0, 3, 1'b0, 6'b100011, 1'b0);
    do_reset(6'b100011);
    run_instr(6'b000000);
    run_instr(6'b100011);
    run_instr(6'b000100);
    run_instr(6'b001000);
    // Sixteen jumps wrap the 4-bit counter.
    repeat (16) run_instr(6'b000010);
    repeat (60) run_instr(rand_op());
    run_instr(6'b010001);
    run_instr(6'b101011);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sb.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle sequencer for the MIPS datapath: program counter, instruction/data memory, register file and ALU.
- Replaces the single-cycle combinational control. Drives per-state strobes and muxes from opcode, so one memory and one ALU are shared across cycles.
- Adds a memory-ready handshake, a sticky halt on illegal opcodes, and a retired-instruction counter for benches.

Parameters:
CNT_WIDTH, 32, width of instr_retired counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
opcode  input  6  IR[31:26], sampled in DECODE
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (datapath ANDs with zero)
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
mem_to_reg  output  1  register write data: 0=ALUOut, 1=MDR
reg_dst  output  1  write register: 0=rt, 1=rd
reg_write  output  1  register file write enable
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
alu_op  output  2  00=add, 01=sub, 10=funct, 11=opcode-immediate
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
state  output  4  current state encoding (debug)
halted  output  1  sticky illegal-opcode flag
instr_retired  output  CNT_WIDTH  completed instruction count

Behaviour:
- Reset: rst is sampled on rising clk.
  - While rst=1, every control output is forced to 0.
  - Next edge loads state=FETCH(0), halted=0, instr_retired=0.
  - Reset mid-instruction abandons the instruction with no write strobe.
- State encoding: FETCH 0, DECODE 1, MEM_ADR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9, IMM_EXEC 10, IMM_WB 11, HALT 15.
- Outputs are Moore, decoded from state. Exceptions: pc_write/ir_write in FETCH and state advance in FETCH, MEM_READ, MEM_WRITE are gated by mem_ready. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; pc_write=ir_write=mem_ready. Holds until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 -> EXECUTE
  - 100011, 101011 -> MEM_ADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000/001100/001101/001010 -> IMM_EXEC (macro-dependent, see Optional Feature)
  - anything else -> HALT
- MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_READ if lw, MEM_WRITE if sw.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1, held until mem_ready. Then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10. Goes to FETCH.
- IMM_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11. Goes to IMM_WB.
- IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- HALT: all strobes 0, halted=1. Stays in HALT until rst; the counter is frozen.
- Latency with mem_ready=1: beq/j 3 cycles, R/sw/imm 4 cycles, lw 5 cycles. Each cycle mem_ready=0 adds one cycle in FETCH/MEM_READ/MEM_WRITE.
- instr_retired increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB, BRANCH, JUMP or IMM_WB. It wraps modulo 2^CNT_WIDTH.
- rst and a retire in the same cycle: rst wins, counter=0.

Optional Feature:
MC_CTRL_IMM_EN
- Defined: opcodes 001000 (addi), 001100 (andi), 001101 (ori) and 001010 (slti) go DECODE -> IMM_EXEC -> IMM_WB.
- Undefined: states 10/11 are not built and those opcodes go to HALT as illegal.

Test Plan:
- rst=1 asserted while in MEM_READ of a lw -> all strobes 0 during reset; after the edge state=0, instr_retired=0, no reg_write seen.
- opcode=000000, mem_ready=1 -> state sequence 0,1,6,7,0; in state 7 reg_write=1 and reg_dst=1; instr_retired 0->1.
- opcode=100011, mem_ready=0 for 3 cycles in MEM_READ -> state 3 held 4 cycles with mem_read=1, i_or_d=1; then state 4; 8 cycles total.
- opcode=000100 -> states 0,1,8; in state 8 pc_write_cond=1, pc_source=01, alu_op=01, pc_write=0.
- opcode=001000:
  - without MC_CTRL_IMM_EN -> state=15, halted=1 for 20+ cycles, counter frozen;
  - with the macro -> states 0,1,10,11,0, counter +1.
- CNT_WIDTH=4, 16 consecutive opcode=000010 -> instr_retired counts 1..15 then 0; pc_write=1 and pc_source=10 in each JUMP state.
